// File: rtl/wb_stage_grf.sv
// rtl/wb_stage_grf.sv - MIPS write-back stage with 32x32 register file and retire counter
//
// Decodes the latched W-stage instruction, selects the write-back value,
// commits it into the register file and serves two bypassed D-stage reads.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_W, pc_W              W-stage instruction (0 = bubble) and its PC
//   pcPlus8_W                  link value for jal
//   aluRes_W                   ALU result / load address (byte lane select)
//   extImm_W                   extended immediate (lui result)
//   dmData_W                   raw aligned data-memory word
//   hiloData_W                 HI/LO value for mfhi/mflo
//   rs_addr_D, rt_addr_D       D-stage read addresses
//   rs_data_D, rt_data_D       D-stage read data with write-through bypass
//   wb_we, wb_addr, wb_data    write-back triple for forwarding (zeroed when idle)
//   retire_cnt                 count of committed non-bubble instructions

module wb_stage_grf #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_W,
   input  logic [31:0] pc_W,
   input  logic [31:0] pcPlus8_W,
   input  logic [31:0] aluRes_W,
   input  logic [31:0] extImm_W,
   input  logic [31:0] dmData_W,
   input  logic [31:0] hiloData_W,
   input  logic [4:0]  rs_addr_D,
   input  logic [4:0]  rt_addr_D,
   output logic [31:0] rs_data_D,
   output logic [31:0] rt_data_D,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] retire_cnt
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LB      = 6'b100000;
   localparam logic [5:0] OP_LH      = 6'b100001;
   localparam logic [5:0] OP_LW      = 6'b100011;

   localparam logic [5:0] FN_MFHI    = 6'b010000;
   localparam logic [5:0] FN_MFLO    = 6'b010010;
   localparam logic [5:0] FN_ADD     = 6'b100000;
   localparam logic [5:0] FN_SUB     = 6'b100010;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_SLT     = 6'b101010;
   localparam logic [5:0] FN_SLTU    = 6'b101011;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;

   assign op    = instr_W[31:26];
   assign funct = instr_W[5:0];
   assign rt    = instr_W[20:16];
   assign rd    = instr_W[15:11];

   // PC, rs field and shamt are not needed for write-back; folded here so
   // they are visibly consumed.
   logic unused_ok;
   assign unused_ok = ^{pc_W, PC_RESET, instr_W[25:21], instr_W[10:6]};

   // Little-endian lane extraction for sub-word loads
   logic [7:0]  lb_byte;
   logic [15:0] lh_half;

   always_comb begin
      lb_byte = dmData_W[7:0];
      case (aluRes_W[1:0])
         2'd0: lb_byte = dmData_W[7:0];
         2'd1: lb_byte = dmData_W[15:8];
         2'd2: lb_byte = dmData_W[23:16];
         2'd3: lb_byte = dmData_W[31:24];
         default: lb_byte = dmData_W[7:0];
      endcase
      lh_half = aluRes_W[1] ? dmData_W[31:16] : dmData_W[15:0];
   end

   logic        dec_we;
   logic [4:0]  dec_dst;
   logic [31:0] dec_data;

   always_comb begin
      dec_we   = 1'b0;
      dec_dst  = 5'd0;
      dec_data = 32'd0;
      case (op)
         OP_SPECIAL: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                  dec_we   = 1'b1;
                  dec_dst  = rd;
                  dec_data = aluRes_W;
               end
               FN_MFHI, FN_MFLO: begin
                  dec_we   = 1'b1;
                  dec_dst  = rd;
                  dec_data = hiloData_W;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            dec_we   = 1'b1;
            dec_dst  = rt;
            dec_data = aluRes_W;
         end
         OP_LUI: begin
            dec_we   = 1'b1;
            dec_dst  = rt;
            dec_data = extImm_W;
         end
         OP_LW: begin
            dec_we   = 1'b1;
            dec_dst  = rt;
            dec_data = dmData_W;
         end
         OP_LH: begin
            dec_we   = 1'b1;
            dec_dst  = rt;
            dec_data = {{16{lh_half[15]}}, lh_half};
         end
         OP_LB: begin
            dec_we   = 1'b1;
            dec_dst  = rt;
            dec_data = {{24{lb_byte[7]}}, lb_byte};
         end
         OP_JAL: begin
            dec_we   = 1'b1;
            dec_dst  = 5'd31;
            dec_data = pcPlus8_W;
         end
         default: ;
      endcase
   end

   // Writes to $0 are dropped here so forwarding logic never sees them
   assign wb_we   = dec_we && (dec_dst != 5'd0);
   assign wb_addr = wb_we ? dec_dst  : 5'd0;
   assign wb_data = wb_we ? dec_data : 32'd0;

   // Entry 0 is never written; reads of $0 are forced to zero below
   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (wb_we) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rs_data_D = 32'd0;
      if (rs_addr_D != 5'd0) begin
         if (wb_we && (wb_addr == rs_addr_D)) begin
            rs_data_D = wb_data;
         end else begin
            rs_data_D = regs[rs_addr_D];
         end
      end
   end

   always_comb begin
      rt_data_D = 32'd0;
      if (rt_addr_D != 5'd0) begin
         if (wb_we && (wb_addr == rt_addr_D)) begin
            rt_data_D = wb_data;
         end else begin
            rt_data_D = regs[rt_addr_D];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retire_cnt <= 32'd0;
      end else if (instr_W != 32'd0) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end

endmodule
